masked_mul_arbiter: RTL and testbench

//   Shares one masked_hpc4_mul instance among NUM_REQ requesters (e.g. S-box

---
 rtl/masked_mul_arbiter.sv | 166 ++++++++++++++++
 tb/tb_masked_mul_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_mul_arbiter.sv
// masked_mul_arbiter
//   Shares one masked multiplier among NUM_REQ requesters. The arbiter is
//   round-robin, and it issues an operation only when the PRNG has a fresh
//   word set ready. Each result goes back to the requester that issued it,
//   using a {valid, tag} pipeline that is as deep as the multiplier latency.
//   A flush FSM stops new issues and waits until the pipeline is empty.
//
// Ports (S = NUM_SHARES*BIT_WIDTH)
//   in_clock, in_reset        clock, synchronous active-high reset
//   in_req_valid / out_req_ready   per-requester handshake (ready is one-hot)
//   in_req_a / in_req_b       operand shares; requester k at [k*S +: S]
//   in_rand_valid / out_rand_ready PRNG handshake (ready == issue)
//   out_mul_a / out_mul_b     multiplier operands (zero when idle)
//   in_mul_c                  multiplier result
//   out_resp_valid / out_resp_c    one-hot response strobe and result shares
//   in_flush / out_flush_done request drain, one-cycle completion pulse
//   out_busy                  at least one operation in flight
//
// FSM states
//   state    | meaning
//   ST_RUN   | normal arbitration; in_flush moves to ST_DRAIN
//   ST_DRAIN | no issue; wait for the tag pipeline to empty
//   ST_DONE  | flush complete; out_flush_done high; back to ST_RUN

module masked_mul_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int NUM_SHARES  = 2,
  parameter int BIT_WIDTH   = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                                      in_clock,
  input  logic                                      in_reset,
  input  logic [NUM_REQ-1:0]                        in_req_valid,
  output logic [NUM_REQ-1:0]                        out_req_ready,
  input  logic [NUM_REQ*NUM_SHARES*BIT_WIDTH-1:0]   in_req_a,
  input  logic [NUM_REQ*NUM_SHARES*BIT_WIDTH-1:0]   in_req_b,
  input  logic                                      in_rand_valid,
  output logic                                      out_rand_ready,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]           out_mul_a,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]           out_mul_b,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]           in_mul_c,
  output logic [NUM_REQ-1:0]                        out_resp_valid,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]           out_resp_c,
  input  logic                                      in_flush,
  output logic                                      out_flush_done,
  output logic                                      out_busy
);

  localparam int S     = NUM_SHARES * BIT_WIDTH;
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                             state_q, state_d;
  logic [TAG_W-1:0]                   ptr_q, ptr_d;
  logic [MUL_LATENCY-1:0]             vld_q, vld_d;
  logic [MUL_LATENCY-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic                               flush_done_q, flush_done_d;

  logic                               any_req;
  logic                               issue;
  logic                               busy;
  logic [TAG_W-1:0]                   gnt_idx;

  assign any_req = |in_req_valid;
  assign busy    = |vld_q;

  // Round-robin search. Offsets are scanned from the farthest to the
  // nearest, so the last match found is the requester closest to ptr_q.
  always_comb begin
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (in_req_valid[k] &&
            ((int'(ptr_q) + i == k) || (int'(ptr_q) + i == k + NUM_REQ))) begin
          gnt_idx = TAG_W'(k);
        end
      end
    end
  end

  // Randomness is never reused: without a fresh word set nothing issues.
  // A flush request blocks issue in the same cycle.
  assign issue = (state_q == ST_RUN) & ~in_flush & in_rand_valid & any_req & ~in_reset;
  assign out_rand_ready = issue;

  // Only the granted shares drive the multiplier. When idle its inputs are
  // forced to zero, so stale shares are never held there.
  always_comb begin
    out_req_ready = '0;
    out_mul_a     = '0;
    out_mul_b     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (issue && (gnt_idx == TAG_W'(k))) begin
        out_req_ready[k] = 1'b1;
        out_mul_a        = in_req_a[k*S +: S];
        out_mul_b        = in_req_b[k*S +: S];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
    end
  end

  always_comb begin
    vld_d    = '0;
    tag_d    = '0;
    vld_d[0] = issue;
    tag_d[0] = gnt_idx;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (in_flush) state_d = ST_DRAIN;
      ST_DRAIN: if (!busy)    state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign flush_done_d = (state_d == ST_DONE);

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q      <= ST_RUN;
      ptr_q        <= '0;
      vld_q        <= '0;
      tag_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      vld_q        <= vld_d;
      tag_q        <= tag_d;
      flush_done_q <= flush_done_d;
    end
  end

  // When reset is high in the same cycle, the response strobe is masked.
  // This drops in-flight results instead of signalling them.
  always_comb begin
    out_resp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      out_resp_valid[k] = vld_q[MUL_LATENCY-1] &&
                          (tag_q[MUL_LATENCY-1] == TAG_W'(k)) && !in_reset;
    end
  end

  assign out_resp_c     = in_mul_c;
  assign out_flush_done = flush_done_q;
  assign out_busy       = busy;

endmodule

// File: tb/tb_masked_mul_arbiter.sv
module tb_masked_mul_arbiter;

  localparam int NR = 3;
  localparam int S  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*S-1:0] req_a, req_b;
  logic            rand_valid, rand_ready;
  logic [S-1:0]    mul_a, mul_b, mul_c;
  logic [NR-1:0]   resp_valid;
  logic [S-1:0]    resp_c;
  logic            flush, flush_done, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  masked_mul_arbiter #(
    .NUM_REQ(3), .NUM_SHARES(2), .BIT_WIDTH(4), .MUL_LATENCY(1)
  ) dut (
    .in_clock      (clk),
    .in_reset      (rst),
    .in_req_valid  (req_valid),
    .out_req_ready (req_ready),
    .in_req_a      (req_a),
    .in_req_b      (req_b),
    .in_rand_valid (rand_valid),
    .out_rand_ready(rand_ready),
    .out_mul_a     (mul_a),
    .out_mul_b     (mul_b),
    .in_mul_c      (mul_c),
    .out_resp_valid(resp_valid),
    .out_resp_c    (resp_c),
    .in_flush      (flush),
    .out_flush_done(flush_done),
    .out_busy      (busy)
  );

  // GF(2^4) multiply with reduction polynomial x^4 + x + 1
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, aa, bb;
    p = 4'h0; aa = a; bb = b;
    for (int i = 0; i < 4; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [3:0] unmask(input logic [7:0] v);
    return v[3:0] ^ v[7:4];
  endfunction

  function automatic logic [7:0] share(input logic [3:0] x);
    logic [3:0] m;
    m = 4'($urandom);
    return {x ^ m, m};
  endfunction

  // Stand-in for the latency-1 masked multiplier. It re-randomises the
  // output sharing on every cycle.
  always @(posedge clk) mul_c <= share(gf_mul(unmask(mul_a), unmask(mul_b)));

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; rand_valid = 1'b0; flush = 1'b0;
    req_a = '0; req_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 3'b111; rand_valid = 1'b1; flush = 1'b0;
    req_a = 24'($urandom); req_b = 24'($urandom);
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL reset_no_grant got %b exp 000", req_ready);
    end
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 3'b000 || flush_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got resp=%b done=%b busy=%b exp 000 0 0",
               resp_valid, flush_done, busy);
    end
    checks++;
    if (mul_a !== 8'h00 || rand_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle_mul got a=%h rr=%b exp 00 0", mul_a, rand_ready);
    end
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b010; rand_valid = 1'b1;
    req_a = '0; req_b = '0;
    req_a[15:8] = 8'h65;
    req_b[15:8] = share(4'h2);
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b010 || rand_ready !== 1'b1) begin
      errors++; $display("FAIL single_grant got %b/%b exp 010/1", req_ready, rand_ready);
    end
    checks++;
    if (mul_a !== 8'h65) begin
      errors++; $display("FAIL single_mul_a got %h exp 65", mul_a);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (resp_valid !== 3'b010 || unmask(resp_c) !== 4'h6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_resp got v=%b c=%h busy=%b exp 010 6 1",
               resp_valid, unmask(resp_c), busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (resp_valid !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL single_after got v=%b busy=%b exp 000 0", resp_valid, busy);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [3:0] prev_p;
    int         prev_k;
    int         k;
    do_reset();
    prev_k = -1; prev_p = 4'h0;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        req_valid = 3'b111; rand_valid = 1'b1;
        req_a = 24'($urandom); req_b = 24'($urandom);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (i < 6) begin
        k = i % 3;
        checks++;
        if (req_ready !== 3'(1 << k)) begin
          errors++; $display("FAIL rr_grant%0d got %b exp %b", i, req_ready, 3'(1 << k));
        end
      end
      if (prev_k >= 0) begin
        checks++;
        if (resp_valid !== 3'(1 << prev_k) || unmask(resp_c) !== prev_p) begin
          errors++;
          $display("FAIL rr_resp%0d got v=%b c=%h exp %b %h",
                   i, resp_valid, unmask(resp_c), 3'(1 << prev_k), prev_p);
        end
      end
      if (i < 6) begin
        prev_k = i % 3;
        prev_p = gf_mul(unmask(req_a[prev_k*S +: S]), unmask(req_b[prev_k*S +: S]));
      end
      next_cycle();
    end
  endtask

  task automatic test_rand_gate();
    logic [2:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid = 3'b001;
      rand_valid = (i != 1);
      req_a = 24'($urandom) | 24'h1; req_b = 24'($urandom) | 24'h1;
      exp_rdy = (i != 1) ? 3'b001 : 3'b000;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_rdy || rand_ready !== (i != 1)) begin
        errors++;
        $display("FAIL rand_gate%0d got %b/%b exp %b/%b", i, req_ready, rand_ready,
                 exp_rdy, (i != 1));
      end
      if (i == 1) begin
        checks++;
        if (mul_a !== 8'h00 || mul_b !== 8'h00) begin
          errors++; $display("FAIL rand_gate_zero got a=%h b=%h exp 00 00", mul_a, mul_b);
        end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_flush();
    logic [3:0] p;
    do_reset();
    req_valid = 3'b100; rand_valid = 1'b1;
    req_a = 24'($urandom); req_b = 24'($urandom);
    p = gf_mul(unmask(req_a[23:16]), unmask(req_b[23:16]));
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL flush_pre_grant got %b exp 100", req_ready);
    end
    next_cycle();
    // Flush stays high across DRAIN and DONE. It must be ignored there.
    for (int c = 0; c < 4; c++) begin
      flush = (c < 3);
      req_valid = 3'b111; rand_valid = 1'b1;
      req_a = 24'($urandom); req_b = 24'($urandom);
      @(negedge clk);
      checks++;
      if (req_ready !== ((c == 3) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL flush_grant_c%0d got %b exp %b", c, req_ready,
                           (c == 3) ? 3'b001 : 3'b000);
      end
      checks++;
      if (flush_done !== (c == 2)) begin
        errors++; $display("FAIL flush_done_c%0d got %b exp %b", c, flush_done, (c == 2));
      end
      if (c == 0) begin
        checks++;
        if (resp_valid !== 3'b100 || unmask(resp_c) !== p || busy !== 1'b1) begin
          errors++;
          $display("FAIL flush_resp got v=%b c=%h busy=%b exp 100 %h 1",
                   resp_valid, unmask(resp_c), busy, p);
        end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req_valid = 3'b010; rand_valid = 1'b1;
    req_a = 24'($urandom); req_b = 24'($urandom);
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL rstmid_grant got %b exp 010", req_ready);
    end
    next_cycle();
    rst = 1'b1; req_valid = 3'b111;
    @(negedge clk);
    checks++;
    if (resp_valid !== 3'b000 || req_ready !== 3'b000) begin
      errors++; $display("FAIL rstmid_drop got v=%b rdy=%b exp 000 000", resp_valid, req_ready);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 3'b000 || busy !== 1'b0 || req_ready !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_after got v=%b busy=%b rdy=%b exp 000 0 001",
               resp_valid, busy, req_ready);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    logic [3:0] exp_q[NR][$];
    logic [3:0] p;
    int         mptr, prev_k, k, ops;
    bit         exp_issue;
    do_reset();
    mptr = 0; prev_k = -1; ops = 0;
    for (int i = 0; i < 301; i++) begin
      if (i < 300) begin
        req_valid  = 3'($urandom_range(0, 7));
        rand_valid = ($urandom_range(0, 3) != 0);
        req_a = 24'($urandom); req_b = 24'($urandom);
      end else begin
        idle_inputs();
      end
      exp_issue = rand_valid && (req_valid != 3'b000);
      k = -1;
      for (int d = 0; d < NR && k < 0; d++) begin
        if (req_valid[(mptr + d) % NR]) k = (mptr + d) % NR;
      end
      @(negedge clk);
      checks++;
      if (req_ready !== (exp_issue ? 3'(1 << k) : 3'b000) || rand_ready !== exp_issue) begin
        errors++;
        $display("FAIL rnd_grant%0d got %b/%b exp %b/%b", i, req_ready, rand_ready,
                 exp_issue ? 3'(1 << k) : 3'b000, exp_issue);
      end
      checks++;
      if (exp_issue ? (mul_a !== req_a[k*S +: S] || mul_b !== req_b[k*S +: S])
                    : (mul_a !== 8'h00 || mul_b !== 8'h00)) begin
        errors++; $display("FAIL rnd_mul%0d got a=%h b=%h", i, mul_a, mul_b);
      end
      checks++;
      if (resp_valid !== ((prev_k >= 0) ? 3'(1 << prev_k) : 3'b000)) begin
        errors++; $display("FAIL rnd_resp_valid%0d got %b exp %b", i, resp_valid,
                           (prev_k >= 0) ? 3'(1 << prev_k) : 3'b000);
      end
      if (prev_k >= 0) begin
        p = exp_q[prev_k].pop_front();
        checks++;
        if (unmask(resp_c) !== p) begin
          errors++; $display("FAIL rnd_resp_c%0d got %h exp %h", i, unmask(resp_c), p);
        end
      end
      if (exp_issue) begin
        exp_q[k].push_back(gf_mul(unmask(req_a[k*S +: S]), unmask(req_b[k*S +: S])));
        mptr = (k + 1) % NR;
        prev_k = k;
        ops++;
      end else begin
        prev_k = -1;
      end
      next_cycle();
    end
    checks++;
    if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || ops == 0) begin
      errors++; $display("FAIL rnd_drain got ops=%0d pending=%0d", ops,
                         exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    test_reset();
    test_single();
    test_round_robin();
    test_rand_gate();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
